// File: rtl/maze_uart_pkg.sv
// ------------------------------------------------------------------
// maze_uart_pkg: shared types and constants for the MazeRunner UART link
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package maze_uart_pkg;

  localparam int         BAUD_DIV_DEF = 5208;
  localparam int         TMO_CYC_DEF  = 1 << 20;
  localparam logic [7:0] ACK_BYTE     = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [0:0] {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_e;

  typedef enum logic [0:0] {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_e;

  // 8N1 frame as it leaves the shifter, LSB first: start, data, stop.
  function automatic logic [9:0] tx_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_trx.sv
// ------------------------------------------------------------------
// uart_trx: 8N1 receiver (sync, bit FSM, byte-valid pulse) and transmitter
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_trx
  import maze_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_vld_o,
  output logic       rx_ferr_o,
  output logic       rx_start_o,
  output logic       rx_busy_o,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  localparam int            CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  logic sync1_q, sync2_q, prev_q;
  logic rx_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_fall = prev_q & ~sync2_q;

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_bit_end, rx_half_end;

  assign rx_bit_end  = (rx_cnt_q == BIT_END);
  assign rx_half_end = (rx_cnt_q == HALF_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      // A start bit that is high again at mid-bit was only a glitch.
      RX_START: if (rx_half_end) rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_end && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_bit_end) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_vld_o   = 1'b0;
    rx_ferr_o  = 1'b0;
    rx_start_o = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_start_o = rx_fall;
      end
      RX_START: if (rx_half_end) rx_cnt_d = '0;
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d  = '0;
          rx_vld_o  = sync2_q;
          rx_ferr_o = ~sync2_q;
        end
      end
      default: rx_cnt_d = '0;
    endcase
  end

  assign rx_byte_o = rx_shift_q;
  assign rx_busy_o = (rx_state_q != RX_IDLE);

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_bit_end, tx_last;

  assign tx_bit_end = (tx_cnt_q == BIT_END);
  assign tx_last    = tx_bit_end && (tx_bit_q == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (tx_start_i) tx_state_d = TX_SHIFT;
      TX_SHIFT: if (tx_last) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // Shifting in ones leaves the line idle-high once the stop bit is out.
  always_comb begin
    tx_cnt_d   = '0;
    tx_bit_d   = '0;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: if (tx_start_i) tx_shift_d = tx_frame(tx_data_i);
      TX_SHIFT: begin
        tx_cnt_d = tx_cnt_q + CW'(1);
        tx_bit_d = tx_bit_q;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
        end
      end
      default: tx_shift_d = '1;
    endcase
  end

  assign tx_o      = tx_shift_q[0];
  assign tx_busy_o = (tx_state_q == TX_SHIFT);
  assign tx_done_o = (tx_state_q == TX_SHIFT) && tx_last;

endmodule

`default_nettype wire

// File: rtl/uart_cmd_wrapper.sv
// ------------------------------------------------------------------
// uart_cmd_wrapper: assembles two UART bytes into a 16-bit command, sends response
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_cmd_wrapper
  import maze_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int TMO_CYC  = TMO_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  localparam int            TW      = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_END = TW'(TMO_CYC - 1);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_ferr, rx_start, rx_busy;

  uart_trx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_trx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (RX),
    .tx_o       (TX),
    .rx_byte_o  (rx_byte),
    .rx_vld_o   (rx_vld),
    .rx_ferr_o  (rx_ferr),
    .rx_start_o (rx_start),
    .rx_busy_o  (rx_busy),
    .tx_start_i (send_resp),
    .tx_data_i  (resp),
    .tx_busy_o  (tx_busy),
    .tx_done_o  (resp_sent)
  );

  asm_state_e    asm_q, asm_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          rdy_q, rdy_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  // Idle time only counts while nothing is arriving on RX.
  assign tmo_hit = (asm_q == WAIT_LO) && (tmo_q == TMO_END) && !rx_start && !rx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q <= WAIT_HI;
      hi_q  <= '0;
      cmd_q <= '0;
      rdy_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      asm_q <= asm_d;
      hi_q  <= hi_d;
      cmd_q <= cmd_d;
      rdy_q <= rdy_d;
      tmo_q <= tmo_d;
    end
  end

  always_comb begin
    asm_d = asm_q;
    case (asm_q)
      WAIT_HI: if (rx_vld) asm_d = WAIT_LO;
      WAIT_LO: if (rx_vld || rx_ferr || tmo_hit) asm_d = WAIT_HI;
      default: asm_d = WAIT_HI;
    endcase
  end

  // A completing byte overrides a simultaneous consumer clear.
  always_comb begin
    hi_d  = hi_q;
    cmd_d = cmd_q;
    rdy_d = rdy_q & ~clr_cmd_rdy;
    tmo_d = (asm_q == WAIT_LO && !rx_busy && !rx_start) ? tmo_q + TW'(1) : '0;
    case (asm_q)
      WAIT_HI: begin
        if (rx_vld) begin
          hi_d  = rx_byte;
          rdy_d = 1'b0;
        end
      end
      WAIT_LO: begin
        if (rx_vld) begin
          cmd_d = {hi_q, rx_byte};
          rdy_d = 1'b1;
        end
      end
      default: rdy_d = 1'b0;
    endcase
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = rdy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_wrapper.sv
// ------------------------------------------------------------------
// tb_uart_cmd_wrapper: directed scoreboard bench for uart_cmd_wrapper
// Revision: 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_cmd_wrapper;
  import maze_uart_pkg::*;

  localparam int BD  = 16;
  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, tx_busy;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic        prev_rdy = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_wrapper #(
    .BAUD_DIV (BD),
    .TMO_CYC  (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .resp        (resp),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy)
  );

  always @(negedge clk) begin
    prev_rdy <= cmd_rdy;
    if (cmd_rdy === 1'b1 && prev_rdy !== 1'b1) obs_q.push_back(cmd);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0, input bit clr_stop = 1'b0);
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = ~bad_stop;
    clr_cmd_rdy = clr_stop;
    tick(BD);
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic remote_rx(output logic [7:0] b);
    int n;
    n = 0;
    b = '0;
    while (TX !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("remote_start_seen", 16'(n < 400), 16'd1);
    repeat (BD / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      b[i] = TX;
    end
    repeat (BD) @(negedge clk);
    chk("remote_stop", 16'(TX), 16'd1);
  endtask

  task automatic check_cmds(input string tag);
    int n;
    logic [15:0] e;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) chk(tag, obs_q.pop_front(), e);
      else chk({tag, "_missing"}, 16'hxxxx, e);
    end
    chk({tag, "_extra"}, 16'(obs_q.size()), 16'd0);
    obs_q.delete();
  endtask

  initial begin
    logic [7:0] rb;
    int pulses, sent_at;

    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
    tick(5);
    @(negedge clk);
    chk("rst_tx", 16'(TX), 16'd1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rdy", 16'(cmd_rdy), 16'd0);
    chk("rst_sent", 16'(resp_sent), 16'd0);
    chk("rst_busy", 16'(tx_busy), 16'd0);
    tick(1);
    rst = 1'b0;
    tick(20);

    // Basic command, held until cleared
    exp_q.push_back(16'h1234);
    send_byte(8'h12);
    send_byte(8'h34);
    check_cmds("cmd_1234");
    tick(100);
    @(negedge clk);
    chk("hold_rdy", 16'(cmd_rdy), 16'd1);
    chk("hold_cmd", cmd, 16'h1234);
    tick(1);
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    chk("clr_rdy", 16'(cmd_rdy), 16'd0);

    // Response frame timing, second request mid-frame ignored
    pulses = 0;
    sent_at = 0;
    fork
      remote_rx(rb);
      begin
        resp = ACK_BYTE;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        for (int k = 1; k <= 400; k++) begin
          @(negedge clk);
          if (k == 1) chk("tx_start_low", 16'(TX), 16'd0);
          if (k == 2) chk("tx_busy_on", 16'(tx_busy), 16'd1);
          if (k == 50) begin send_resp = 1'b1; resp = 8'h00; end
          if (k == 51) send_resp = 1'b0;
          if (resp_sent === 1'b1) begin
            pulses++;
            if (sent_at == 0) sent_at = k;
          end
        end
      end
    join
    chk("tx_byte", 16'(rb), 16'h00A5);
    chk("tx_pulses", 16'(pulses), 16'd1);
    chk("tx_sent_at", 16'(sent_at), 16'd160);
    chk("tx_idle_line", 16'(TX), 16'd1);
    chk("tx_busy_off", 16'(tx_busy), 16'd0);

    // Gap just under the timeout keeps the high byte
    exp_q.push_back(16'hC3D4);
    send_byte(8'hC3);
    tick(TMO - 30);
    send_byte(8'hD4);
    check_cmds("tmo_near");

    // Gap beyond the timeout discards the high byte
    exp_q.push_back(16'h0005);
    send_byte(8'hAB);
    tick(TMO + 10);
    send_byte(8'h00);
    send_byte(8'h05);
    check_cmds("tmo_expire");

    // Framing error byte dropped
    exp_q.push_back(16'hBEEF);
    send_byte(8'h77, 1'b1);
    tick(20);
    send_byte(8'hBE);
    send_byte(8'hEF);
    check_cmds("framing");

    // Short RX glitch is not a byte
    exp_q.push_back(16'h1122);
    RX = 1'b0;
    tick(3);
    RX = 1'b1;
    tick(100);
    send_byte(8'h11);
    send_byte(8'h22);
    check_cmds("glitch");

    // Reset mid low byte with a frame in flight
    send_byte(8'h33);
    resp = 8'h3C;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    RX = 1'b0;
    tick(40);
    rst = 1'b1;
    RX = 1'b1;
    tick(2);
    @(negedge clk);
    chk("midrst_tx", 16'(TX), 16'd1);
    chk("midrst_rdy", 16'(cmd_rdy), 16'd0);
    chk("midrst_busy", 16'(tx_busy), 16'd0);
    chk("midrst_cmd", cmd, 16'h0000);
    tick(1);
    rst = 1'b0;
    tick(200);
    exp_q.push_back(16'h0F0F);
    send_byte(8'h0F);
    send_byte(8'h0F);
    check_cmds("after_rst");

    // Full duplex
    exp_q.push_back(16'h5A5A);
    fork
      begin
        send_byte(8'h5A);
        send_byte(8'h5A);
      end
      remote_rx(rb);
      begin
        resp = ACK_BYTE;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
      end
    join
    chk("duplex_tx", 16'(rb), 16'h00A5);
    check_cmds("duplex_rx");

    // Clear coinciding with next high byte
    exp_q.push_back(16'h6677);
    send_byte(8'h66, 1'b0, 1'b1);
    @(negedge clk);
    chk("race_rdy", 16'(cmd_rdy), 16'd0);
    chk("race_cmd_stable", cmd, 16'h5A5A);
    send_byte(8'h77);
    check_cmds("race_next");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
